// File: rtl/booth_mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   booth_state_e : controller states
//   booth_sel_e   : recoder addend selection
//   calc_ew()     : extended operand width. One spare bit keeps unsigned operands
//                   positive once they are treated as signed, and the width is
//                   rounded up to even so the operand is consumed two bits at a time.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } booth_state_e;

  typedef enum logic [2:0] {
    SelZero,
    SelPa,
    SelP2a,
    SelMa,
    SelM2a
  } booth_sel_e;

  // Round width+1 up to the next even number.
  function automatic int unsigned calc_ew(int unsigned width);
    return ((width + 2) / 2) * 2;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth digit recoder.
//   bits_i   : multiplier window P[2:0]
//   a_i      : +A, EW+1 bits
//   s_i      : -A, EW+1 bits
//   addend_o : selected addend (0, +-A, +-2A), EW+1 bits
//   add_en_o : low when the digit is zero
module booth_r4_recoder
  import booth_mul_pkg::*;
#(
  parameter int unsigned EW = 10
) (
  input  logic [2:0]  bits_i,
  input  logic [EW:0] a_i,
  input  logic [EW:0] s_i,
  output logic [EW:0] addend_o,
  output logic        add_en_o
);

  booth_sel_e sel;

  always_comb begin
    sel = SelZero;
    unique case (bits_i)
      3'b001, 3'b010: sel = SelPa;
      3'b011:         sel = SelP2a;
      3'b100:         sel = SelM2a;
      3'b101, 3'b110: sel = SelMa;
      default:        sel = SelZero;
    endcase
  end

  // Doubling cannot overflow: A and S carry at least one redundant sign bit.
  always_comb begin
    addend_o = '0;
    add_en_o = 1'b1;
    unique case (sel)
      SelZero: add_en_o = 1'b0;
      SelPa:   addend_o = a_i;
      SelP2a:  addend_o = {a_i[EW-1:0], 1'b0};
      SelMa:   addend_o = s_i;
      SelM2a:  addend_o = {s_i[EW-1:0], 1'b0};
      default: add_en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
//   clk, rst     : clock and synchronous active-high reset
//   start        : request, accepted when ready
//   is_signed    : 1 = two's-complement operands, sampled with start
//   multiplicand : operand A, sampled with start
//   multiplier   : operand B, sampled with start
//   ready        : idle or done, a new start is accepted
//   busy         : iterating
//   done         : one-cycle pulse, product valid
//   product      : 2*WIDTH-bit result, held until the next completion
module booth_r4_seq_mul
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned EW   = calc_ew(WIDTH);
  localparam int unsigned N    = EW / 2;
  localparam int unsigned PW   = 2 * EW + 2;
  localparam int unsigned CntW = $clog2(N + 1);

  booth_state_e state_q, state_d;

  logic [EW:0]          a_q, a_d;
  logic [EW:0]          s_q, s_d;
  logic [PW-1:0]        p_q, p_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 accept;
  logic                 last_iter;
  logic [EW:0]          a_ext;
  logic [EW-1:0]        b_ext;
  logic [EW:0]          addend;
  logic                 add_en;
  logic [EW:0]          sum;
  logic [PW-1:0]        p_run;

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last_iter = (state_q == StRun) && (cnt_q == CntW'(1));

  // The mode bit gates the sign extension; unsigned operands always zero-extend.
  assign a_ext = {{(EW + 1 - WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
  assign b_ext = {{(EW - WIDTH){is_signed & multiplier[WIDTH-1]}}, multiplier};

  booth_r4_recoder #(
    .EW (EW)
  ) u_recoder (
    .bits_i   (p_q[2:0]),
    .a_i      (a_q),
    .s_i      (s_q),
    .addend_o (addend),
    .add_en_o (add_en)
  );

  // Add into the upper half (carry out dropped), then shift the whole P right by 2.
  always_comb begin
    sum   = p_q[PW-1:EW+1] + (add_en ? addend : '0);
    p_run = PW'($signed({sum, p_q[EW:0]}) >>> 2);
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      s_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      s_q       <= s_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_iter) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    a_d       = a_q;
    s_d       = s_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      a_d   = a_ext;
      s_d   = -a_ext;
      p_d   = {{(EW + 1){1'b0}}, b_ext, 1'b0};
      cnt_d = CntW'(N);
    end else if (state_q == StRun) begin
      p_d   = p_run;
      cnt_d = cnt_q - CntW'(1);
      if (last_iter) begin
        product_d = p_run[2*WIDTH:1];
      end
    end
  end

  // Outputs.
  always_comb begin
    ready = (state_q == StIdle) || (state_q == StDone);
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
module tb_booth_r4_seq_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic        sg8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] prod8;

  logic        start5 = 1'b0;
  logic        sg5 = 1'b0;
  logic [4:0]  a5 = '0;
  logic [4:0]  b5 = '0;
  logic        ready5, busy5, done5;
  logic [9:0]  prod5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mul #(
    .WIDTH (8)
  ) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .is_signed    (sg8),
    .multiplicand (a8),
    .multiplier   (b8),
    .ready        (ready8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  booth_r4_seq_mul #(
    .WIDTH (5)
  ) dut5 (
    .clk          (clk),
    .rst          (rst),
    .start        (start5),
    .is_signed    (sg5),
    .multiplicand (a5),
    .multiplier   (b5),
    .ready        (ready5),
    .busy         (busy5),
    .done         (done5),
    .product      (prod5)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: start pulse, wait for done, check latency and product.
  task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk(32'(done8), 32'd1, {tag, "_done"});
    chk(32'(cycles), 32'd6, {tag, "_latency"});
    chk(32'(busy_cnt), 32'd5, {tag, "_busy_cycles"});
    chk(32'(prod8), 32'(exp), {tag, "_product"});
  endtask

  task automatic op5(input logic sg, input logic [4:0] a, input logic [4:0] b,
                     input logic [9:0] exp, input string tag);
    int cycles;
    @(negedge clk);
    start5 = 1'b1; sg5 = sg; a5 = a; b5 = b;
    @(negedge clk);
    start5 = 1'b0;
    cycles = 1;
    while (!done5 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    chk(32'(done5), 32'd1, {tag, "_done"});
    chk(32'(cycles), 32'd4, {tag, "_latency"});
    chk(32'(prod5), 32'(exp), {tag, "_product"});
  endtask

  initial begin
    int cycles;
    int n_done;
    logic [15:0] exp16;
    logic [7:0]  ra, rb;
    logic        rs;
    int          ia, ib;

    // Reset state.
    repeat (3) @(negedge clk);
    chk(32'(ready8), 32'd1, "rst_ready8");
    chk(32'(busy8), 32'd0, "rst_busy8");
    chk(32'(done8), 32'd0, "rst_done8");
    chk(32'(prod8), 32'd0, "rst_product8");
    chk(32'(ready5), 32'd1, "rst_ready5");
    chk(32'(prod5), 32'd0, "rst_product5");
    rst = 1'b0;

    // Signed corner cases.
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s_m128_m128");
    op8(1'b1, 8'hFF, 8'h01, 16'hFFFF, "s_m1_1");

    // Mode changes the result for the same bits.
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_255_255");
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1_m1");

    // Odd width.
    op5(1'b1, 5'h10, 5'h10, 10'h100, "w5_s_m16_m16");
    op5(1'b0, 5'h1F, 5'h1F, 10'h3C1, "w5_u_31_31");

    // Start pulsed throughout RUN is ignored.
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(32'(busy8), 32'd1, "ign_busy");
      start8 = 1'b1; a8 = 8'd2 + 8'(i); b8 = 8'd3;
    end
    @(negedge clk);
    start8 = 1'b0;
    chk(32'(done8), 32'd1, "ign_done");
    chk(32'(prod8), 32'h003F, "ign_product");
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk(32'(n_done), 32'd0, "ign_extra_done");
    chk(32'(ready8), 32'd1, "ign_ready_after");

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'd50; b8 = 8'd50;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(32'(ready8), 32'd1, "abort_ready");
    chk(32'(busy8), 32'd0, "abort_busy");
    chk(32'(prod8), 32'd0, "abort_product");
    n_done = 0;
    repeat (10) begin
      if (done8) n_done++;
      @(negedge clk);
    end
    chk(32'(n_done), 32'd0, "abort_no_done");
    op8(1'b0, 8'd3, 8'd4, 16'd12, "after_abort_3x4");

    // Back-to-back: start held through DONE with new operands.
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b1; a8 = 8'd5; b8 = 8'd6;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'hFD;
    cycles = 1;
    while (!done8 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    chk(32'(done8), 32'd1, "b2b_first_done");
    chk(32'(prod8), 32'd30, "b2b_first_product");
    @(negedge clk);
    start8 = 1'b0;
    chk(32'(busy8), 32'd1, "b2b_reaccept_busy");
    cycles = 1;
    while (!done8 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    chk(32'(done8), 32'd1, "b2b_second_done");
    chk(32'(cycles), 32'd6, "b2b_spacing");
    chk(32'(prod8), 32'hFED4, "b2b_second_product");

    // Random sweep against an integer reference.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      ia = rs ? int'($signed(ra)) : int'(ra);
      ib = rs ? int'($signed(rb)) : int'(rb);
      exp16 = 16'(ia * ib);
      op8(rs, ra, rb, exp16, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
